// File: rtl/lvds_rx_phase_ctrl.sv
// LVDS 7:1 receive PLL phase calibration sequencer.
// Resets the PLL, sweeps psda, then centres on the widest passing window.
module lvds_rx_phase_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 65535,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         SAMPLE_WORDS  = 32,
  parameter logic [6:0] TRAIN_PATTERN = 7'b1100011,
  parameter int         MIN_WIN       = 3,
  parameter logic [3:0] DUTY_CODE     = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic [3:0] fdly,
  input  logic [6:0] rx_data,
  input  logic       rx_valid,
  output logic       busy,
  output logic       aligned,
  output logic       fail,
  output logic [3:0] win_start,
  output logic [4:0] win_len
);

  typedef enum logic [2:0] {
    IDLE, PLL_RST, WAIT_LOCK, SETTLE,
    SAMPLE, EVAL, DONE, FAILED
  } state_t;

  localparam logic [31:0] RST_END = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TMO_END = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] STL_END = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] SMP_END = 32'(SAMPLE_WORDS - 1);
  localparam logic [31:0] EVL_END = 32'd16;
  localparam logic [4:0]  MIN_LEN = 5'(MIN_WIN);

  state_t      state, nxt;
  logic [31:0] cnt;
  logic [15:0] pass_map;
  logic [3:0]  phase;
  logic        lock_s1, lock_sync;
  logic        mismatch, word_end;
  logic [15:0] rot;
  logic [4:0]  run_len;
  logic        run_on;

  assign dutyda   = DUTY_CODE;
  assign fdly     = 4'b0000;
  assign mismatch = rx_data != TRAIN_PATTERN;
  assign word_end = rx_valid && (mismatch || cnt == SMP_END);

  // Length of the run of ones starting at bit cnt, wrapping past bit 15.
  always_comb begin
    rot     = 16'({pass_map, pass_map} >> cnt[3:0]);
    run_len = '0;
    run_on  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_on  = run_on & rot[i];
      run_len = run_len + {4'b0, run_on};
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (start) nxt = PLL_RST;
      PLL_RST:
        if (cnt == RST_END) nxt = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_sync) nxt = SETTLE;
        else if (cnt == TMO_END) nxt = FAILED;
      SETTLE:
        if (!lock_sync) nxt = PLL_RST;
        else if (cnt == STL_END) nxt = SAMPLE;
      SAMPLE:
        if (!lock_sync) nxt = PLL_RST;
        else if (word_end) nxt = (phase == 4'd15) ? EVAL : SETTLE;
      EVAL:
        if (cnt == EVL_END) nxt = (win_len < MIN_LEN) ? FAILED : DONE;
      DONE:
        if (!lock_sync || start) nxt = PLL_RST;
      FAILED:
        if (start) nxt = PLL_RST;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1   <= 1'b0;
      lock_sync <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      pass_map  <= '0;
      phase     <= '0;
      pll_reset <= 1'b1;
      psda      <= '0;
      busy      <= 1'b0;
      aligned   <= 1'b0;
      fail      <= 1'b0;
      win_start <= '0;
      win_len   <= '0;
    end else begin
      lock_s1   <= pll_lock;
      lock_sync <= lock_s1;
      state     <= nxt;
      pll_reset <= nxt inside {IDLE, PLL_RST, FAILED};
      busy      <= !(nxt inside {IDLE, DONE, FAILED});
      aligned   <= nxt == DONE;
      fail      <= nxt == FAILED;

      if (nxt != state) cnt <= '0;
      else if (state != SAMPLE || rx_valid) cnt <= cnt + 32'd1;

      if (nxt == PLL_RST) begin
        pass_map  <= '0;
        phase     <= '0;
        psda      <= '0;
        win_start <= '0;
        win_len   <= '0;
      end

      if (state == SAMPLE && (nxt == SETTLE || nxt == EVAL)) begin
        pass_map[phase] <= !mismatch;
        if (phase != 4'd15) begin
          phase <= phase + 4'd1;
          psda  <= phase + 4'd1;
        end
      end

      // Strict compare keeps the smallest start on ties.
      if (state == EVAL && cnt < EVL_END && run_len > win_len) begin
        win_start <= cnt[3:0];
        win_len   <= run_len;
      end

      if (state == EVAL && nxt == DONE)
        psda <= win_start + win_len[4:1];

      if (nxt == FAILED) begin
        psda <= '0;
        if (state == EVAL) win_start <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lvds_rx_phase_ctrl.sv
// Directed bench for lvds_rx_phase_ctrl.
// PLL and deserializer models plus a window-search reference.
module tb_lvds_rx_phase_ctrl;

  localparam int SETTLE = 8;
  localparam int SWORDS = 8;
  localparam int RSTC   = 16;
  localparam int TMO    = 200;
  localparam int MINW   = 3;
  localparam logic [6:0] PAT = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pll_lock;
  logic       pll_reset;
  logic [3:0] psda, dutyda, fdly;
  logic [6:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       busy, aligned, fail;
  logic [3:0] win_start;
  logic [4:0] win_len;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] good = '0;
  int  lock_delay = 100;
  logic lock_en = 1'b1;
  logic lock_ok = 1'b0;
  int  lcnt = 0;
  int  cyc = 0;

  int exp_start = 0, exp_len = 0, exp_psda = 0;

  lvds_rx_phase_ctrl #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO),
    .SETTLE_CYCLES(SETTLE), .SAMPLE_WORDS(SWORDS),
    .TRAIN_PATTERN(PAT), .MIN_WIN(MINW),
    .DUTY_CODE(4'b1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .pll_lock(pll_lock), .pll_reset(pll_reset),
    .psda(psda), .dutyda(dutyda), .fdly(fdly),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .aligned(aligned), .fail(fail),
    .win_start(win_start), .win_len(win_len)
  );

  always #5 clk = ~clk;

  assign pll_lock = lock_en & lock_ok;

  // PLL: locks lock_delay cycles after its reset is released.
  always @(negedge clk) begin
    if (pll_reset) begin
      lcnt = 0;
      lock_ok = 1'b0;
    end else if (lcnt < lock_delay) lcnt = lcnt + 1;
    else lock_ok = 1'b1;
  end

  // Deserializer: good phases always match; bad ones corrupt odd cycles.
  always @(negedge clk) begin
    cyc = cyc + 1;
    rx_valid = (cyc % 3) != 0;
    rx_data = (good[psda] || cyc[0] == 1'b0) ? PAT : (PAT ^ 7'h10);
  end

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Longest circular run of ones; ties go to the smallest start.
  function automatic void model(input logic [15:0] m);
    int bs, bl, l;
    bs = 0;
    bl = 0;
    if (m == 16'hFFFF) bl = 16;
    else
      for (int s = 0; s < 16; s++)
        if (m[s] && !m[(s + 15) % 16]) begin
          l = 0;
          while (m[(s + l) % 16]) l++;
          if (l > bl) begin
            bl = l;
            bs = s;
          end
        end
    exp_len = bl;
    exp_start = (bl >= MINW) ? bs : 0;
    exp_psda = (bl >= MINW) ? (bs + bl / 2) % 16 : 0;
  endfunction

  initial begin : cmp
    logic [3:0] prev;
    int since;
    prev = '0;
    since = 0;
    forever begin
      @(negedge clk);
      chk("dutyda", int'(dutyda), 8);
      chk("fdly", int'(fdly), 0);
      if (rst_n) begin
        chk("excl", int'(aligned) + int'(fail) + int'(busy), int'(aligned | fail | busy));
        if (fail) begin
          chk("fail_rst", int'(pll_reset), 1);
          chk("fail_psda", int'(psda), 0);
          chk("fail_wlen", int'(win_len), exp_len);
          chk("fail_wst", int'(win_start), 0);
        end
        if (aligned) begin
          chk("done_psda", int'(psda), exp_psda);
          chk("done_wst", int'(win_start), exp_start);
          chk("done_wlen", int'(win_len), exp_len);
          chk("done_rst", int'(pll_reset), 0);
        end
        if (psda != prev) begin
          chk("psda_step", int'(psda == prev + 4'd1 || psda == 4'd0 || aligned), 1);
          if (psda == prev + 4'd1 && !aligned)
            chk("settle_gap", int'(since >= SETTLE), 1);
          since = 0;
        end else since++;
        prev = psda;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!aligned && !fail && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(n < 6000), 1);
  endtask

  task automatic wait_psda(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (psda != v && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(psda), int'(v));
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    chk("rst_pllrst", int'(pll_reset), 1);
    chk("rst_psda", int'(psda), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_aligned", int'(aligned), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_wlen", int'(win_len), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_pllrst", int'(pll_reset), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_psda", int'(psda), 0);

    // Clean window 5..10, with an ignored start mid-sweep.
    good = 16'h07E0;
    model(good);
    pulse_start();
    chk("busy_start", int'(busy), 1);
    wait_psda(4'd3, "reach_p3");
    pulse_start();
    repeat (3) @(negedge clk);
    chk("busy_start_ignored", int'(psda >= 4'd3), 1);
    wait_end("clean_end");
    chk("clean_aligned", int'(aligned), 1);
    chk("clean_ws", int'(win_start), 5);
    chk("clean_wl", int'(win_len), 6);
    chk("clean_psda", int'(psda), 8);

    // Lock loss in DONE: fast drop, full reset pulse, resweep.
    lock_en = 1'b0;
    n = 0;
    while (aligned && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drop_latency", int'(n <= 3 && !aligned), 1);
    n = 1;
    while (pll_reset && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drop_rst_width", n - 1, RSTC);
    lock_en = 1'b1;
    wait_end("relock_end");
    chk("relock_aligned", int'(aligned), 1);
    chk("relock_psda", int'(psda), 8);

    // Circular window 14,15,0,1.
    pulse_start();
    good = 16'hC003;
    model(good);
    wait_end("circ_end");
    chk("circ_aligned", int'(aligned), 1);
    chk("circ_ws", int'(win_start), 14);
    chk("circ_wl", int'(win_len), 4);
    chk("circ_psda", int'(psda), 0);

    // Every phase passes.
    pulse_start();
    good = 16'hFFFF;
    model(good);
    wait_end("all_end");
    chk("all_ws", int'(win_start), 0);
    chk("all_wl", int'(win_len), 16);
    chk("all_psda", int'(psda), 8);

    // Window too narrow.
    pulse_start();
    good = 16'h0018;
    model(good);
    wait_end("small_end");
    chk("small_fail", int'(fail), 1);
    chk("small_wl", int'(win_len), 2);
    chk("small_psda", int'(psda), 0);
    chk("small_pllrst", int'(pll_reset), 1);

    // Recovery from FAIL.
    pulse_start();
    good = 16'h07E0;
    model(good);
    wait_end("recover_end");
    chk("recover_aligned", int'(aligned), 1);
    chk("recover_psda", int'(psda), 8);

    // Lock loss while sampling phase 7.
    pulse_start();
    wait_psda(4'd7, "reach_p7");
    repeat (SETTLE + 1) @(negedge clk);
    lock_en = 1'b0;
    n = 0;
    while (!pll_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_pllrst", int'(pll_reset), 1);
    chk("abort_psda", int'(psda), 0);
    lock_en = 1'b1;
    n = 0;
    while (psda == 4'd0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("restart_phase", int'(psda), 1);
    wait_end("abort_end");
    chk("abort_aligned", int'(aligned), 1);

    // Lock never returns: timeout after TMO cycles.
    lock_en = 1'b0;
    n = 0;
    while (aligned && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_len = 0;
    n = 0;
    while (pll_reset && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!fail && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_fail", int'(fail), 1);
    repeat (4) @(negedge clk);
    chk("timeout_stays", int'(fail), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lvds_rx_phase_ctrl.md
Name: lvds_rx_phase_ctrl

Overview:
Calibration sequencer for the LVDS 7:1 receive PLL. It pulses the PLL reset and waits for lock. It then sweeps the 4-bit dynamic phase-shift code (psda) across all 16 steps and checks the deserialized clock-lane word against the training pattern at each step. It programs the centre of the longest passing window and monitors lock afterwards. It sits between the receive-PLL wrapper's dynamic-adjust inputs and the deserializer output.

Parameters:
RST_CYCLES, 16, width of the pll_reset pulse in clk cycles (≥2)
LOCK_TIMEOUT, 65535, cycles to wait for synchronized lock before failing
SETTLE_CYCLES, 64, idle cycles after each psda change before sampling
SAMPLE_WORDS, 32, consecutive rx_valid words compared per phase step
TRAIN_PATTERN, 7'b1100011, expected clock-lane word
MIN_WIN, 3, minimum passing window length accepted (1..16)
DUTY_CODE, 4'b1000, constant driven on dutyda

Ports:
clk  in  1  system clock; all logic is synchronous to it
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins calibration from IDLE, DONE or FAIL
pll_lock  in  1  PLL lock, asynchronous; 2-FF synchronized internally
pll_reset  out  1  active-high PLL reset
psda  out  4  dynamic phase code to the PLL
dutyda  out  4  dynamic duty code, constant DUTY_CODE
fdly  out  4  fine delay, constant 4'b0000
rx_data  in  7  deserialized clock-lane word
rx_valid  in  1  rx_data qualifier
busy  out  1  high in any state other than IDLE, DONE or FAIL
aligned  out  1  high only in DONE
fail  out  1  high only in FAIL
win_start  out  4  start index of the chosen window
win_len  out  5  length of the chosen window, 0..16

Behaviour:
- Reset (async, rst_n=0) values: state=IDLE, pll_reset=1, psda=0, busy=0, aligned=0, fail=0, win_start=0, win_len=0, pass map=0, all counters=0.
- dutyda and fdly are constant at all times, including during reset.
- IDLE: pll_reset=1. On start, go to PLL_RST.
- PLL_RST: clear the pass map, phase index and window outputs; psda=0; pll_reset=1 for exactly RST_CYCLES cycles; then go to WAIT_LOCK.
- WAIT_LOCK: pll_reset=0.
  - Synchronized lock high: go to SETTLE.
  - Counter reaches LOCK_TIMEOUT first: go to FAIL.
- SETTLE: hold psda = phase index for SETTLE_CYCLES cycles; rx_valid is ignored; then go to SAMPLE.
- SAMPLE: count rx_valid words up to SAMPLE_WORDS.
  - The phase passes only if every counted word equals TRAIN_PATTERN.
  - On the first mismatch, mark the phase failed and end sampling immediately.
  - Set pass_map[phase] to the result.
  - Phase index < 15: increment the index, drive psda with the new value on the next cycle, and go to SETTLE.
  - Phase index = 15: go to EVAL.
- EVAL: find the longest run of 1s in pass_map, treated as circular (bit 15 is adjacent to bit 0).
  - Ties: take the smallest start index.
  - All 16 bits set: start=0, len=16.
  - EVAL may take up to 17 cycles.
  - len < MIN_WIN: win_start=0, win_len=len, psda=0, go to FAIL.
  - Otherwise psda = (start + len/2) mod 16, with len/2 truncated; go to DONE.
- DONE: aligned=1; psda is held.
  - Synchronized lock drops: aligned=0 on the next cycle, go to PLL_RST (automatic recalibration).
  - start pulse: go to PLL_RST.
- FAIL: fail=1, pll_reset=1, psda=0. Leave only on start.
- Lock loss during SETTLE or SAMPLE: abort the sweep and go to PLL_RST; the pass map is cleared.
- start while busy: ignored.
- pll_lock glitches shorter than 2 cycles may be missed; lock is sampled only through the synchronizer.
- Outputs are registered. psda changes only on a state-transition cycle, never mid-SAMPLE.

Test Plan:
- Reset and idle: rst_n low, then high, no start → pll_reset=1, psda=0, busy=0, aligned=0, fail=0; dutyda=4'b1000, fdly=0 throughout.
- Clean window: pattern correct only for phases 5..10, lock after 100 cycles → pass map 0x07E0, win_start=5, win_len=6, psda=8, aligned=1.
- Circular window: phases 14,15,0,1 pass → win_start=14, win_len=4, psda=0. Then all phases pass → win_start=0, win_len=16, psda=8.
- Window too small: only phases 3,4 pass → fail=1, win_len=2, psda=0, pll_reset=1. A second start with a good window → DONE.
- Lock timeout: pll_lock held low with LOCK_TIMEOUT=200 → fail=1 at 200 cycles after pll_reset deasserts.
- Lock loss: drop pll_lock while in DONE → aligned=0 within 3 cycles, pll_reset high for RST_CYCLES, full sweep re-runs. Drop lock mid-SAMPLE at phase 7 → sweep restarts at phase 0.
